mpadder_arbiter: RTL and testbench
==================================

# mpadder_arbiter

Controller that shares one `mpadder` (1027-bit multi-cycle add/sub) between `NREQ` requesters, e.g. the Montgomery multiplier and the exponentiation loop. It arbitrates pending requests and latches the winner's operands. It sequences the adder's `start`/`done` handshake, holding `subtract` and the operands stable for the whole operation. It returns the 1028-bit result to the winning requester with a one-cycle valid pulse.

## Interface
- `NREQ`, 2, number of requesters (2..4)
- `W`, 1027, operand width; result width is `W+1`
- `clk` input 1: clock
- `resetn` input 1: reset, synchronous, active-low; shared with the `mpadder` instance
- `req_i` input NREQ: per-requester request, level; held until `ack_o` for that port
- `sub_i` input NREQ: per-requester operation; 1 = a−b, 0 = a+b
- `a_i` input NREQ*W: packed operand A; port i at `[i*W +: W]`
- `b_i` input NREQ*W: packed operand B
- `ack_o` output NREQ: one-cycle pulse; operands of that port have been captured
- `res_valid_o` output NREQ: one-cycle pulse; `result_o` belongs to that port
- `result_o` output W+1: registered result; holds until the next result
- `busy_o` output 1: high whenever the state is not IDLE
- `add_start_o` output 1: adder start, one-cycle pulse
- `add_sub_o` output 1: adder `subtract`; held constant from ISSUE through WAIT
- `add_a_o` output W: held operand register A
- `add_b_o` output W: held operand register B
- `add_result_i` input W+1: adder result
- `add_done_i` input 1: adder done pulse

## Operation
- **States:**
  - IDLE: if any `req_i` is set, pick the winner and latch `a`, `b` and `sub` of the winner → ISSUE; otherwise stay.
  - ISSUE: `add_start_o`=1 and `ack_o[win]`=1 → WAIT.
  - WAIT: on `add_done_i`, latch `add_result_i` into `result_o` → RESP.
  - RESP: `res_valid_o[win]`=1 → IDLE.
- **Arbitration:** evaluated only in IDLE (see Configuration).
- **Operand stability:** `add_a_o`, `add_b_o` and `add_sub_o` change only on the IDLE→ISSUE edge. This is required because the adder resamples `subtract` every cycle and reloads B while idle.
- **Spurious done:** `add_done_i` outside WAIT is ignored.
- **Requester rules:**
  - Operands need only be valid while `req_i` is high and before `ack_o`.
  - Deassert the request the cycle after `ack_o`. If `req_i` is still high in the next IDLE, it is a new request.
- **Reset:** all registers clear to 0: state=IDLE, all outputs 0, `result_o`=0, winner pointer=0.
- **Reset mid-operation:** the operation is abandoned and no `res_valid_o` is issued. The adder resets on the same edge.
- **Width rules:**
  - Result bit W is the adder carry, passed through unmodified.
  - For subtraction, bit W=1 means a≥b (no borrow).

## Timing
- Request sampled in IDLE at cycle 0 → `ack_o` and `add_start_o` at cycle 1.
- The current adder returns `add_done_i` at cycle 8 → `res_valid_o` at cycle 9 → IDLE at cycle 10.
- Throughput: one operation per 10 cycles. Requests are accepted only in IDLE.
- Latency scales with the adder's done delay; the controller never counts cycles itself.
- Simultaneous requests in IDLE: exactly one `ack_o` is issued. The loser stays pending, and its request is granted in the next IDLE, 10 cycles later.
- `busy_o` is high from cycle 1 through cycle 9.

## Configuration
- **`MPADDER_ARB_RR_EN` defined:**
  - Round-robin arbitration. After a grant to port i, priority starts at port i+1 mod NREQ.
  - The pointer updates on the IDLE→ISSUE edge.
- **Not defined:**
  - Fixed priority; the lowest index wins.
  - No pointer register; a continuously requesting port 0 starves the others.

## Structure
- **Package `mpadder_pkg`:**
  - Constant `MP_W = 1027`.
  - State enum `arb_state_t`: IDLE, ISSUE, WAIT, RESP, 2-bit encoding.
  - `NREQ` limits.
- **Sub-module `mpadder_rr_pick`:** combinational.
  - Inputs: request vector and priority pointer.
  - Outputs: one-hot grant and winner index.
  - Under fixed priority the pointer is tied to 0.
- **Top:** FSM, operand/result registers, pointer register, and the `mpadder` instance left to the integrator.

## Test plan
- Reset mid-WAIT → no `res_valid_o`.
  - Stimulus: port0 requests a=5, b=3, sub=0; assert resetn=0 for one cycle in WAIT.
  - Required: all outputs 0; next request completes normally.
- Single add → correct result and cycles.
  - Stimulus: port0, a=5, b=3, sub=0.
  - Required: `ack_o[0]` at cycle 1, `res_valid_o[0]` at cycle 9, `result_o`=8.
- Subtract → correct result and stable control.
  - Stimulus: port1, a=3, b=5, sub=1.
  - Required: `result_o` = 2^1027 − 2, bit 1026 set, bit 1027 = 0 (borrow).
  - Required: `add_sub_o` stays 1 through WAIT.
- Full-width carry → `result_o` = 2^1027.
  - Stimulus: a = 2^1027−1, b = 1, add.
- Simultaneous requests under `MPADDER_ARB_RR_EN`.
  - Stimulus: both ports hold req continuously.
  - Required: grants alternate 0, 1, 0, 1 at cycles 1, 11, 21, 31.
  - Without the macro: port 0 wins every time.
- Operand change after `ack_o` → result unaffected.
  - Stimulus: change `a_i` right after `ack_o`; inject a spurious `add_done_i` in IDLE.
  - Required: result uses the captured operands; the spurious done causes no state change.

Source files
------------

// File: rtl/mpadder_pkg.sv
// rtl/mpadder_pkg.sv - shared constants and state type for the mpadder arbiter
package mpadder_pkg;

  localparam int MP_W     = 1027;
  localparam int NREQ_MIN = 2;
  localparam int NREQ_MAX = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } arb_state_t;

endpackage

// File: rtl/mpadder_rr_pick.sv
// rtl/mpadder_rr_pick.sv - combinational rotating-priority picker, search starts at ptr_i
module mpadder_rr_pick #(
  parameter int NREQ = 2,
  parameter int IW   = 1
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [IW-1:0]   ptr_i,
  output logic [NREQ-1:0] gnt_o,
  output logic [IW-1:0]   idx_o
);

  logic found;
  int   j;

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    found = 1'b0;
    j     = 0;
    for (int k = 0; k < NREQ; k++) begin
      j = (int'(ptr_i) + k) % NREQ;
      if (!found && req_i[j]) begin
        found    = 1'b1;
        gnt_o[j] = 1'b1;
        idx_o    = IW'(j);
      end
    end
  end

endmodule

// File: rtl/mpadder_arbiter.sv
// rtl/mpadder_arbiter.sv - shares one multi-cycle mpadder between NREQ requesters; MPADDER_ARB_RR_EN selects round-robin
module mpadder_arbiter
  import mpadder_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int W    = MP_W
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic [NREQ-1:0]     req_i,
  input  logic [NREQ-1:0]     sub_i,
  input  logic [NREQ*W-1:0]   a_i,
  input  logic [NREQ*W-1:0]   b_i,
  output logic [NREQ-1:0]     ack_o,
  output logic [NREQ-1:0]     res_valid_o,
  output logic [W:0]          result_o,
  output logic                busy_o,
  output logic                add_start_o,
  output logic                add_sub_o,
  output logic [W-1:0]        add_a_o,
  output logic [W-1:0]        add_b_o,
  input  logic [W:0]          add_result_i,
  input  logic                add_done_i
);

  localparam int IW = $clog2(NREQ);

  arb_state_t      state_q, state_d;
  logic [IW-1:0]   win_q, win_d;
  logic [NREQ-1:0] ack_q, ack_d;
  logic [NREQ-1:0] res_valid_q, res_valid_d;
  logic [W:0]      result_q, result_d;
  logic            start_q, start_d;
  logic            sub_q, sub_d;
  logic [W-1:0]    a_q, a_d;
  logic [W-1:0]    b_q, b_d;
  logic [IW-1:0]   ptr;
  logic [NREQ-1:0] pick_gnt;
  logic [IW-1:0]   pick_idx;

`ifdef MPADDER_ARB_RR_EN
  logic [IW-1:0]   ptr_q, ptr_d;
  assign ptr = ptr_q;
`else
  assign ptr = '0;
`endif

  mpadder_rr_pick #(.NREQ(NREQ), .IW(IW)) u_pick (
    .req_i (req_i),
    .ptr_i (ptr),
    .gnt_o (pick_gnt),
    .idx_o (pick_idx)
  );

  always_comb begin
    state_d     = state_q;
    win_d       = win_q;
    ack_d       = '0;
    res_valid_d = '0;
    result_d    = result_q;
    start_d     = 1'b0;
    sub_d       = sub_q;
    a_d         = a_q;
    b_d         = b_q;
`ifdef MPADDER_ARB_RR_EN
    ptr_d       = ptr_q;
`endif
    case (state_q)
      IDLE: begin
        // Operands are captured only here so the adder sees them constant until RESP.
        if (|req_i) begin
          state_d = ISSUE;
          win_d   = pick_idx;
          a_d     = a_i[int'(pick_idx)*W +: W];
          b_d     = b_i[int'(pick_idx)*W +: W];
          sub_d   = sub_i[pick_idx];
          ack_d   = pick_gnt;
          start_d = 1'b1;
`ifdef MPADDER_ARB_RR_EN
          ptr_d   = (int'(pick_idx) == NREQ - 1) ? '0 : pick_idx + IW'(1);
`endif
        end
      end
      ISSUE: state_d = WAIT;
      WAIT: begin
        if (add_done_i) begin
          state_d     = RESP;
          result_d    = add_result_i;
          res_valid_d = {{(NREQ-1){1'b0}}, 1'b1} << win_q;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q     <= IDLE;
      win_q       <= '0;
      ack_q       <= '0;
      res_valid_q <= '0;
      result_q    <= '0;
      start_q     <= 1'b0;
      sub_q       <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
`ifdef MPADDER_ARB_RR_EN
      ptr_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      win_q       <= win_d;
      ack_q       <= ack_d;
      res_valid_q <= res_valid_d;
      result_q    <= result_d;
      start_q     <= start_d;
      sub_q       <= sub_d;
      a_q         <= a_d;
      b_q         <= b_d;
`ifdef MPADDER_ARB_RR_EN
      ptr_q       <= ptr_d;
`endif
    end
  end

  assign ack_o       = ack_q;
  assign res_valid_o = res_valid_q;
  assign result_o    = result_q;
  assign busy_o      = (state_q != IDLE);
  assign add_start_o = start_q;
  assign add_sub_o   = sub_q;
  assign add_a_o     = a_q;
  assign add_b_o     = b_q;

endmodule

// File: tb/tb_mpadder_arbiter.sv
// tb/tb_mpadder_arbiter.sv - self-checking bench for mpadder_arbiter with a behavioural adder
module tb_mpadder_arbiter;
  import mpadder_pkg::*;

  localparam int NREQ = 2;
  localparam int W    = MP_W;
  localparam logic [W:0]   TWO_W = {1'b1, {W{1'b0}}};
  localparam logic [W-1:0] ONES  = {W{1'b1}};

  logic              clk = 1'b0;
  logic              resetn;
  logic [NREQ-1:0]   req_i, sub_i;
  logic [NREQ*W-1:0] a_i, b_i;
  logic [NREQ-1:0]   ack_o, res_valid_o;
  logic [W:0]        result_o;
  logic              busy_o, add_start_o, add_sub_o;
  logic [W-1:0]      add_a_o, add_b_o;
  logic [W:0]        add_result_i;
  logic              add_done_i, done_m, spur;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int cnt   = 0;

  assign add_done_i = done_m | spur;

  mpadder_arbiter #(.NREQ(NREQ), .W(W)) dut (
    .clk          (clk),
    .resetn       (resetn),
    .req_i        (req_i),
    .sub_i        (sub_i),
    .a_i          (a_i),
    .b_i          (b_i),
    .ack_o        (ack_o),
    .res_valid_o  (res_valid_o),
    .result_o     (result_o),
    .busy_o       (busy_o),
    .add_start_o  (add_start_o),
    .add_sub_o    (add_sub_o),
    .add_a_o      (add_a_o),
    .add_b_o      (add_b_o),
    .add_result_i (add_result_i),
    .add_done_i   (add_done_i)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference arithmetic: W+1-bit sum, or a-b offset by 2^W so bit W reads "no borrow".
  function automatic logic [W:0] ref_op(input logic s, input logic [W-1:0] a, input logic [W-1:0] b);
    if (s) return {1'b0, a} + TWO_W - {1'b0, b};
    return {1'b0, a} + {1'b0, b};
  endfunction

  // Adder stand-in: done arrives in the 7th cycle after the start cycle.
  always @(negedge clk) begin
    done_m = 1'b0;
    if (!resetn) cnt = 0;
    else begin
      if (cnt > 0) begin
        cnt = cnt - 1;
        if (cnt == 0) begin
          done_m       = 1'b1;
          add_result_i = ref_op(add_sub_o, add_a_o, add_b_o);
        end
      end
      if (add_start_o) cnt = 7;
    end
  end

  task automatic chk_int(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: actual=%0d required=%0d", nm, act, exp);
    end
  endtask

  task automatic chk_wide(input string nm, input logic [W:0] act, input logic [W:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: actual carry=%b low=%h required carry=%b low=%h",
               nm, act[W], act[63:0], exp[W], exp[63:0]);
    end
  endtask

  function automatic logic [W-1:0] rand_op();
    logic [W-1:0] r = '0;
    case ($urandom_range(0, 5))
      0: r = ONES;
      1: r = W'($urandom_range(0, 9));
      2: r = '0;
      default: for (int i = 0; i < 33; i++) r = {r[W-33:0], 32'($urandom())};
    endcase
    return r;
  endfunction

  task automatic run_op(input int p, input logic s, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W:0] exp, input string nm);
    int c0, ca, cr;
    bit got, stable;
    @(negedge clk);
    req_i[p] = 1'b1;
    sub_i[p] = s;
    a_i[p*W +: W] = a;
    b_i[p*W +: W] = b;
    c0 = cyc; ca = 0; cr = 0; got = 0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      if (ack_o[p]) begin got = 1; ca = cyc; end
    end
    chk_int({nm, " ack_seen"}, int'(got), 1);
    req_i[p] = 1'b0;
    if (!got) return;
    chk_int({nm, " ack_latency"}, ca - c0, 1);
    chk_int({nm, " start_with_ack"}, int'(add_start_o), 1);
    a_i[p*W +: W] = ~a;
    b_i[p*W +: W] = ~b;
    sub_i[p] = ~s;
    stable = 1; got = 0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      if (res_valid_o[p]) begin got = 1; cr = cyc; end
      else if (add_sub_o !== s || add_a_o !== a || add_b_o !== b) stable = 0;
    end
    chk_int({nm, " res_valid_seen"}, int'(got), 1);
    if (!got) return;
    chk_int({nm, " operands_stable"}, int'(stable), 1);
    chk_int({nm, " res_latency"}, cr - c0, 9);
    chk_wide({nm, " result"}, result_o, exp);
    @(negedge clk);
    chk_int({nm, " idle_after"}, int'(busy_o), 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    resetn = 1'b0;
    @(negedge clk);
    @(negedge clk);
    resetn = 1'b1;
  endtask

  typedef struct {
    int           port;
    logic         sub;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W:0]   exp;
  } vec_t;

  vec_t vecs[6];
  int   gport[$];
  int   gcyc[$];

  initial begin
    int c0;
    bit onehot_ok, res_ok, got;
    logic [W:0] saved;

    vecs[0] = '{0, 1'b0, W'(5), W'(3), (W+1)'(8)};
    vecs[1] = '{1, 1'b1, W'(3), W'(5), TWO_W - (W+1)'(2)};
    vecs[2] = '{0, 1'b0, ONES, W'(1), TWO_W};
    vecs[3] = '{1, 1'b1, W'(5), W'(3), TWO_W + (W+1)'(2)};
    vecs[4] = '{0, 1'b1, W'(7), W'(7), TWO_W};
    vecs[5] = '{1, 1'b0, ONES, ONES, {ONES, 1'b0}};

    resetn = 1'b0; req_i = '0; sub_i = '0; a_i = '0; b_i = '0;
    spur = 1'b0; done_m = 1'b0; add_result_i = '0;
    do_reset();
    @(negedge clk);
    chk_int("reset busy", int'(busy_o), 0);
    chk_int("reset ack", int'(ack_o), 0);
    chk_int("reset res_valid", int'(res_valid_o), 0);
    chk_wide("reset result", result_o, '0);

    for (int i = 0; i < 6; i++)
      run_op(vecs[i].port, vecs[i].sub, vecs[i].a, vecs[i].b, vecs[i].exp, $sformatf("vec%0d", i));
    chk_int("sub borrow bit1026", int'(vecs[1].exp[W-1]), 1);

    // Spurious done in IDLE must leave everything alone.
    saved = result_o;
    @(negedge clk); spur = 1'b1;
    @(negedge clk); spur = 1'b0;
    chk_int("spurious busy", int'(busy_o), 0);
    chk_int("spurious res_valid", int'(res_valid_o), 0);
    @(negedge clk);
    chk_int("spurious busy later", int'(busy_o), 0);
    chk_wide("spurious result", result_o, saved);

    // Reset in the middle of WAIT abandons the operation.
    @(negedge clk);
    req_i[0] = 1'b1; sub_i[0] = 1'b0; a_i[0 +: W] = W'(5); b_i[0 +: W] = W'(3);
    got = 0;
    for (int i = 0; i < 10 && !got; i++) begin @(negedge clk); got = ack_o[0]; end
    chk_int("rst ack_seen", int'(got), 1);
    req_i[0] = 1'b0;
    repeat (3) @(negedge clk);
    resetn = 1'b0;
    @(negedge clk);
    chk_int("rst busy", int'(busy_o), 0);
    chk_int("rst ctl", int'({add_start_o, add_sub_o, ack_o, res_valid_o}), 0);
    chk_wide("rst result", result_o, '0);
    chk_int("rst operands", int'(add_a_o != '0 || add_b_o != '0), 0);
    resetn = 1'b1;
    got = 0;
    for (int i = 0; i < 15; i++) begin @(negedge clk); if (|res_valid_o) got = 1; end
    chk_int("rst no res_valid", int'(got), 0);
    run_op(0, 1'b0, W'(5), W'(3), (W+1)'(8), "post_rst");

    // Both ports request continuously from a fresh pointer.
    do_reset();
    @(negedge clk);
    req_i = 2'b11; sub_i = 2'b10;
    a_i[0 +: W] = W'(10); b_i[0 +: W] = W'(1);
    a_i[W +: W] = W'(20); b_i[W +: W] = W'(4);
    c0 = cyc; onehot_ok = 1; res_ok = 1;
    for (int i = 0; i < 45; i++) begin
      @(negedge clk);
      if (|ack_o) begin
        if ($countones(ack_o) != 1) onehot_ok = 0;
        gport.push_back(ack_o[1] ? 1 : 0);
        gcyc.push_back(cyc - c0);
      end
      if (res_valid_o[0] && result_o !== (W+1)'(11)) res_ok = 0;
      if (res_valid_o[1] && result_o !== TWO_W + (W+1)'(16)) res_ok = 0;
    end
    req_i = '0;
    chk_int("arb onehot", int'(onehot_ok), 1);
    chk_int("arb results", int'(res_ok), 1);
    chk_int("arb grant count", gport.size() >= 4 ? 4 : gport.size(), 4);
    for (int g = 0; g < 4 && g < gport.size(); g++) begin
      chk_int($sformatf("arb grant%0d cycle", g), gcyc[g], 1 + 10 * g);
`ifdef MPADDER_ARB_RR_EN
      chk_int($sformatf("arb grant%0d port", g), gport[g], g % 2);
`else
      chk_int($sformatf("arb grant%0d port", g), gport[g], 0);
`endif
    end
    got = 0;
    for (int i = 0; i < 20 && !got; i++) begin @(negedge clk); got = !busy_o; end
    chk_int("arb drains", int'(got), 1);

    // Random single operations against the arithmetic model.
    for (int i = 0; i < 12; i++) begin
      int p; logic s; logic [W-1:0] ra, rb;
      p  = $urandom_range(0, NREQ - 1);
      s  = 1'($urandom_range(0, 1));
      ra = rand_op();
      rb = rand_op();
      run_op(p, s, ra, rb, ref_op(s, ra, rb), $sformatf("rand%0d", i));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: cycles=%0d limit=50000", cyc);
    $fatal(1);
  end

endmodule
